// File: rtl/selftrig_fill_sequencer.sv
// selftrig_fill_sequencer
//   Control sequencer for the self-triggered acquisition mux. Per fill it issues
//   a checksum init, then for each accepted trigger a waveform header followed by
//   N data bursts, then a fill header and finally the checksum. It also tracks the
//   waveform number, waveform start address and burst count for the headers.
//
// Ports
//   clk, rst_n              acquisition clock, asynchronous active-low reset
//   fill_start, fill_end    fill control pulses
//   trig                    self-trigger request pulse
//   adc_burst_valid         one 8-sample burst ready this cycle
//   fifo_ready              DDR3 write FIFO can accept
//   async_num_bursts[13:0]  data bursts per waveform (0 treated as 1)
//   base_adr[22:0]          DDR3 start address of the fill
//   select_*                registered mux selects (one-hot or idle)
//   checksum_init/_update   registered checksum strobes
//   fifo_wr_en              any select delayed one cycle
//   current_waveform_num, waveform_start_adr, num_fill_bursts  header fields
//   fill_busy, fill_done    fill status
//   dropped_trig[DROP_W-1:0] triggers ignored this fill
//
// Build option
//   SELFTRIG_DROP_CNT_EN    when defined, dropped_trig counts dropped triggers and
//                           lost bursts (saturating); otherwise it is tied to 0.

module selftrig_fill_sequencer #(
  parameter logic [22:0] MAX_WFM = 23'd8388607,
  parameter int unsigned DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_start,
  input  logic              fill_end,
  input  logic              trig,
  input  logic              adc_burst_valid,
  input  logic              fifo_ready,
  input  logic [13:0]       async_num_bursts,
  input  logic [22:0]       base_adr,
  output logic              select_fill_hdr,
  output logic              select_waveform_hdr,
  output logic              select_dat,
  output logic              select_checksum,
  output logic              checksum_init,
  output logic              checksum_update,
  output logic              fifo_wr_en,
  output logic [22:0]       current_waveform_num,
  output logic [22:0]       waveform_start_adr,
  output logic [22:0]       num_fill_bursts,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [DROP_W-1:0] dropped_trig
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ARMED,
    ST_WFM_HDR,
    ST_DATA,
    ST_FILL_HDR,
    ST_CHKSUM
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] burst_left_q, burst_left_d;
  logic        fill_end_pend_q, fill_end_pend_d;

  logic        sel_fill_hdr_q, sel_fill_hdr_d;
  logic        sel_wfm_hdr_q, sel_wfm_hdr_d;
  logic        sel_dat_q, sel_dat_d;
  logic        sel_checksum_q, sel_checksum_d;
  logic        ck_init_q, ck_init_d;
  logic        ck_update_q, ck_update_d;
  logic        fifo_wr_en_q;
  logic        fill_busy_q;
  logic        fill_done_q;
  logic [22:0] wfm_num_q;
  logic [22:0] wfm_adr_q;
  logic [22:0] nfb_q;
  logic [22:0] nfb_inc;
  logic        overflow_q;

  logic        wfm_done;
  logic        drop_trig;
  logic        lost_burst;

  always_comb begin
    state_d         = state_q;
    burst_left_d    = burst_left_q;
    fill_end_pend_d = fill_end_pend_q;
    sel_fill_hdr_d  = 1'b0;
    sel_wfm_hdr_d   = 1'b0;
    sel_dat_d       = 1'b0;
    sel_checksum_d  = 1'b0;
    ck_init_d       = 1'b0;
    ck_update_d     = 1'b0;
    wfm_done        = 1'b0;
    drop_trig       = 1'b0;
    lost_burst      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) state_d = ST_INIT;
      end
      ST_INIT: begin
        ck_init_d       = 1'b1;
        fill_end_pend_d = 1'b0;
        state_d         = ST_ARMED;
      end
      ST_ARMED: begin
        if (fill_end) begin
          state_d   = ST_FILL_HDR;
          drop_trig = trig;
        end else if (trig) begin
          if (wfm_num_q < MAX_WFM) state_d = ST_WFM_HDR;
          else                     drop_trig = 1'b1;
        end
      end
      ST_WFM_HDR: begin
        drop_trig = trig;
        if (fifo_ready) begin
          sel_wfm_hdr_d = 1'b1;
          burst_left_d  = (async_num_bursts == 14'd0) ? 14'd1 : async_num_bursts;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        drop_trig = trig;
        if (fill_end) fill_end_pend_d = 1'b1;
        if (adc_burst_valid) begin
          if (fifo_ready) begin
            sel_dat_d    = 1'b1;
            ck_update_d  = 1'b1;
            burst_left_d = burst_left_q - 14'd1;
            if (burst_left_q == 14'd1) begin
              // A fill_end arriving with the last burst closes the fill too.
              wfm_done        = 1'b1;
              fill_end_pend_d = 1'b0;
              state_d = (fill_end_pend_q || fill_end) ? ST_FILL_HDR : ST_ARMED;
            end
          end else begin
            lost_burst = 1'b1;
          end
        end
      end
      ST_FILL_HDR: begin
        drop_trig = trig;
        if (fifo_ready) begin
          sel_fill_hdr_d = 1'b1;
          state_d        = ST_CHKSUM;
        end
      end
      ST_CHKSUM: begin
        drop_trig = trig;
        if (fifo_ready) begin
          sel_checksum_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The fill header counts itself and the trailing checksum, so the checksum
  // select adds nothing further.
  always_comb begin
    nfb_inc = '0;
    if (sel_wfm_hdr_d || sel_dat_d) nfb_inc = 23'd1;
    else if (sel_fill_hdr_d)        nfb_inc = 23'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      burst_left_q    <= '0;
      fill_end_pend_q <= 1'b0;
      sel_fill_hdr_q  <= 1'b0;
      sel_wfm_hdr_q   <= 1'b0;
      sel_dat_q       <= 1'b0;
      sel_checksum_q  <= 1'b0;
      ck_init_q       <= 1'b0;
      ck_update_q     <= 1'b0;
      fifo_wr_en_q    <= 1'b0;
      fill_busy_q     <= 1'b0;
      fill_done_q     <= 1'b0;
      wfm_num_q       <= '0;
      wfm_adr_q       <= '0;
      nfb_q           <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      burst_left_q    <= burst_left_d;
      fill_end_pend_q <= fill_end_pend_d;
      sel_fill_hdr_q  <= sel_fill_hdr_d;
      sel_wfm_hdr_q   <= sel_wfm_hdr_d;
      sel_dat_q       <= sel_dat_d;
      sel_checksum_q  <= sel_checksum_d;
      ck_init_q       <= ck_init_d;
      ck_update_q     <= ck_update_d;
      fifo_wr_en_q    <= sel_fill_hdr_q | sel_wfm_hdr_q | sel_dat_q | sel_checksum_q;
      fill_busy_q     <= (state_d != ST_IDLE);
      fill_done_q     <= sel_checksum_q;
      if (state_q == ST_INIT) begin
        wfm_num_q  <= '0;
        nfb_q      <= '0;
        wfm_adr_q  <= base_adr;
        overflow_q <= 1'b0;
      end else begin
        nfb_q <= nfb_q + nfb_inc;
        if (wfm_done)      wfm_num_q  <= wfm_num_q + 23'd1;
        if (sel_wfm_hdr_d) wfm_adr_q  <= base_adr + nfb_q;
        if (lost_burst)    overflow_q <= 1'b1;
      end
    end
  end

  // Overflow is kept for debug visibility; nothing downstream consumes it.
  logic unused_overflow;
  assign unused_overflow = overflow_q;

`ifdef SELFTRIG_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_W:0]   drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(drop_trig) + (DROP_W+1)'(lost_burst);
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    if (state_q == ST_INIT)      drop_cnt_d = '0;
    else if (state_q == ST_IDLE) drop_cnt_d = drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_trig = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop  = drop_trig | lost_burst;
  assign dropped_trig = '0;
`endif

  assign select_fill_hdr      = sel_fill_hdr_q;
  assign select_waveform_hdr  = sel_wfm_hdr_q;
  assign select_dat           = sel_dat_q;
  assign select_checksum      = sel_checksum_q;
  assign checksum_init        = ck_init_q;
  assign checksum_update      = ck_update_q;
  assign fifo_wr_en           = fifo_wr_en_q;
  assign current_waveform_num = wfm_num_q;
  assign waveform_start_adr   = wfm_adr_q;
  assign num_fill_bursts      = nfb_q;
  assign fill_busy            = fill_busy_q;
  assign fill_done            = fill_done_q;

endmodule

// File: tb/tb_selftrig_fill_sequencer.sv
module tb_selftrig_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_start, fill_end, trig, adc_burst_valid, fifo_ready;
  logic [13:0] async_num_bursts;
  logic [22:0] base_adr;

  logic        select_fill_hdr, select_waveform_hdr, select_dat, select_checksum;
  logic        checksum_init, checksum_update, fifo_wr_en, fill_busy, fill_done;
  logic [22:0] current_waveform_num, waveform_start_adr, num_fill_bursts;
  logic [7:0]  dropped_trig;

  logic        c_sel_fh, c_sel_wh, c_sel_dat, c_sel_ck, c_ck_init, c_ck_upd, c_wr_en;
  logic        c_busy, c_done;
  logic [22:0] c_wfm_num, c_wfm_adr, c_nfb;
  logic [7:0]  c_dropped;

  int checks = 0;
  int errors = 0;
  int exp_drop;

  selftrig_fill_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_end(fill_end), .trig(trig),
    .adc_burst_valid(adc_burst_valid), .fifo_ready(fifo_ready),
    .async_num_bursts(async_num_bursts), .base_adr(base_adr),
    .select_fill_hdr(select_fill_hdr), .select_waveform_hdr(select_waveform_hdr),
    .select_dat(select_dat), .select_checksum(select_checksum),
    .checksum_init(checksum_init), .checksum_update(checksum_update),
    .fifo_wr_en(fifo_wr_en), .current_waveform_num(current_waveform_num),
    .waveform_start_adr(waveform_start_adr), .num_fill_bursts(num_fill_bursts),
    .fill_busy(fill_busy), .fill_done(fill_done), .dropped_trig(dropped_trig)
  );

  selftrig_fill_sequencer #(.MAX_WFM(23'd2), .DROP_W(8)) dut_cap (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_end(fill_end), .trig(trig),
    .adc_burst_valid(adc_burst_valid), .fifo_ready(fifo_ready),
    .async_num_bursts(async_num_bursts), .base_adr(base_adr),
    .select_fill_hdr(c_sel_fh), .select_waveform_hdr(c_sel_wh),
    .select_dat(c_sel_dat), .select_checksum(c_sel_ck),
    .checksum_init(c_ck_init), .checksum_update(c_ck_upd),
    .fifo_wr_en(c_wr_en), .current_waveform_num(c_wfm_num),
    .waveform_start_adr(c_wfm_adr), .num_fill_bursts(c_nfb),
    .fill_busy(c_busy), .fill_done(c_done), .dropped_trig(c_dropped)
  );

  always #5 clk = ~clk;

  logic [85:0] main_outs;
  assign main_outs = {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
                      checksum_init, checksum_update, fifo_wr_en, current_waveform_num,
                      waveform_start_adr, num_fill_bursts, fill_busy, fill_done, dropped_trig};

  // Strobe log: 0=init 1=wfm_hdr 2=dat 3=fill_hdr 4=checksum 5=fill_done
  int          codes[$];
  int          cycs[$];
  int          cyc = 0;
  int          onehot_err = 0;
  int          wren_err = 0;
  logic        prev_any = 1'b0;
  logic [22:0] nfb_at_fill = '0;
  bit          c_done_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_any <= 1'b0;
    end else begin
      if (fifo_wr_en !== prev_any) wren_err <= wren_err + 1;
      if ($countones({select_fill_hdr, select_waveform_hdr, select_dat, select_checksum}) > 1)
        onehot_err <= onehot_err + 1;
      if (checksum_init)       begin codes.push_back(0); cycs.push_back(cyc); end
      if (select_waveform_hdr) begin codes.push_back(1); cycs.push_back(cyc); end
      if (select_dat)          begin codes.push_back(2); cycs.push_back(cyc); end
      if (select_fill_hdr)     begin codes.push_back(3); cycs.push_back(cyc); nfb_at_fill <= num_fill_bursts; end
      if (select_checksum)     begin codes.push_back(4); cycs.push_back(cyc); end
      if (fill_done)           begin codes.push_back(5); cycs.push_back(cyc); end
      if (c_done) c_done_seen <= 1'b1;
      prev_any <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; fill_start = 0; fill_end = 0; trig = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    codes.delete(); cycs.delete();
  endtask

  task automatic start_fill();
    fill_start = 1'b1; tick(); fill_start = 1'b0; tick();
  endtask

  task automatic pulse_trig();
    trig = 1'b1; tick(); trig = 1'b0;
  endtask

  task automatic pulse_fill_end();
    fill_end = 1'b1; tick(); fill_end = 1'b0;
  endtask

  task automatic wait_cwn(input logic [22:0] target, input int budget);
    for (int i = 0; i < budget && current_waveform_num != target; i++) tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && fill_done !== 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fill_start = 0; fill_end = 0; trig = 0; adc_burst_valid = 0;
    fifo_ready = 1; async_num_bursts = 14'd1; base_adr = '0;
    #12;
    checks++;
    if (main_outs !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", main_outs); end
    tick(); rst_n = 1'b1; tick(); tick();
    checks++;
    if (main_outs !== '0) begin errors++; $display("FAIL idle_outs got %h want 0", main_outs); end
  endtask

  task automatic test_basic_fill();
    int exp_seq[9] = '{0, 1, 2, 2, 2, 2, 3, 4, 5};
    bit ok;
    apply_reset();
    async_num_bursts = 14'd4; base_adr = '0; adc_burst_valid = 1; fifo_ready = 1;
    start_fill();
    pulse_trig();
    wait_cwn(23'd1, 30);
    pulse_fill_end();
    wait_done(30);
    checks++;
    if (fill_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", fill_done); end
    tick();
    checks++;
    if (fill_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", fill_done); end
    ok = (codes.size() == 9);
    if (ok) for (int i = 0; i < 9; i++) if (codes[i] != exp_seq[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_seq got %0d events want 9 in order init,hdr,4xdat,fill,chk,done", codes.size()); end
    checks++;
    if (!ok || cycs[8] != cycs[7] + 1) begin errors++; $display("FAIL basic_done_timing got done/chk mismatch want done one cycle after checksum"); end
    checks++;
    if (nfb_at_fill !== 23'd7) begin errors++; $display("FAIL basic_nfb_at_hdr got %0d want 7", nfb_at_fill); end
    checks++;
    if (num_fill_bursts !== 23'd7) begin errors++; $display("FAIL basic_nfb got %0d want 7", num_fill_bursts); end
    checks++;
    if (current_waveform_num !== 23'd1) begin errors++; $display("FAIL basic_cwn got %0d want 1", current_waveform_num); end
    checks++;
    if (fill_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", fill_busy); end
  endtask

  task automatic test_addresses();
    logic [22:0] exp_adr[3] = '{23'd100, 23'd103, 23'd106};
    apply_reset();
    async_num_bursts = 14'd2; base_adr = 23'd100; adc_burst_valid = 1; fifo_ready = 1;
    start_fill();
    for (int k = 0; k < 3; k++) begin
      pulse_trig();
      wait_cwn(23'(k + 1), 20);
      checks++;
      if (waveform_start_adr !== exp_adr[k]) begin
        errors++; $display("FAIL adr_wfm%0d got %0d want %0d", k, waveform_start_adr, exp_adr[k]);
      end
    end
    pulse_fill_end();
    wait_done(30);
    checks++;
    if (num_fill_bursts !== 23'd11) begin errors++; $display("FAIL adr_nfb got %0d want 11", num_fill_bursts); end
    checks++;
    if (current_waveform_num !== 23'd3) begin errors++; $display("FAIL adr_cwn got %0d want 3", current_waveform_num); end
    tick();
  endtask

  task automatic test_drops();
    apply_reset();
    async_num_bursts = 14'd3; base_adr = '0; adc_burst_valid = 0; fifo_ready = 1;
    start_fill();
    pulse_trig();
    tick();
    pulse_trig();
    adc_burst_valid = 1;
    wait_cwn(23'd1, 20);
    trig = 1; fill_end = 1; tick(); trig = 0; fill_end = 0;
    wait_done(30);
    tick();
    checks++;
    if (dropped_trig !== 8'(exp_drop)) begin errors++; $display("FAIL drop_count got %0d want %0d", dropped_trig, exp_drop); end
    checks++;
    if (current_waveform_num !== 23'd1) begin errors++; $display("FAIL drop_cwn got %0d want 1", current_waveform_num); end
    checks++;
    if (num_fill_bursts !== 23'd6) begin errors++; $display("FAIL drop_nfb got %0d want 6", num_fill_bursts); end
  endtask

  task automatic test_fifo_stall();
    int t0;
    int hdr_cyc;
    int n_hdr;
    apply_reset();
    wren_err = 0; onehot_err = 0;
    async_num_bursts = 14'd1; base_adr = '0; adc_burst_valid = 1; fifo_ready = 1;
    start_fill();
    fifo_ready = 0;
    pulse_trig();
    t0 = cyc;
    repeat (5) tick();
    fifo_ready = 1;
    wait_cwn(23'd1, 20);
    pulse_fill_end();
    wait_done(30);
    tick();
    hdr_cyc = -1; n_hdr = 0;
    foreach (codes[i]) if (codes[i] == 1) begin n_hdr++; hdr_cyc = cycs[i]; end
    checks++;
    if (hdr_cyc - t0 != 6) begin errors++; $display("FAIL stall_delay got %0d want 6", hdr_cyc - t0); end
    checks++;
    if (n_hdr != 1) begin errors++; $display("FAIL stall_hdr_count got %0d want 1", n_hdr); end
    checks++;
    if (codes.size() != 6) begin errors++; $display("FAIL stall_events got %0d want 6", codes.size()); end
    checks++;
    if (wren_err != 0) begin errors++; $display("FAIL wren_align got %0d misaligned want 0", wren_err); end
    checks++;
    if (onehot_err != 0) begin errors++; $display("FAIL select_onehot got %0d violations want 0", onehot_err); end
  endtask

  task automatic test_cap();
    apply_reset();
    c_done_seen = 0;
    async_num_bursts = 14'd1; base_adr = '0; adc_burst_valid = 1; fifo_ready = 1;
    start_fill();
    for (int k = 0; k < 3; k++) begin
      pulse_trig();
      wait_cwn(23'(k + 1), 20);
    end
    pulse_fill_end();
    wait_done(30);
    tick(); tick();
    checks++;
    if (c_wfm_num !== 23'd2) begin errors++; $display("FAIL cap_cwn got %0d want 2", c_wfm_num); end
    checks++;
    if (c_nfb !== 23'd6) begin errors++; $display("FAIL cap_nfb got %0d want 6", c_nfb); end
    checks++;
    if (c_done_seen !== 1'b1) begin errors++; $display("FAIL cap_trailer got %b want 1", c_done_seen); end
    checks++;
    if (c_dropped !== 8'(exp_drop / 2)) begin errors++; $display("FAIL cap_dropped got %0d want %0d", c_dropped, exp_drop / 2); end
  endtask

  task automatic test_reset_mid();
    int exp_seq[6] = '{0, 1, 2, 3, 4, 5};
    bit ok;
    apply_reset();
    async_num_bursts = 14'd2; base_adr = 23'd50; adc_burst_valid = 0; fifo_ready = 1;
    start_fill();
    pulse_trig();
    tick();
    checks++;
    if (fill_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", fill_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (main_outs !== '0) begin errors++; $display("FAIL mid_reset_outs got %h want 0", main_outs); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    codes.delete(); cycs.delete();
    async_num_bursts = 14'd1; adc_burst_valid = 1;
    start_fill();
    pulse_trig();
    wait_cwn(23'd1, 20);
    pulse_fill_end();
    wait_done(30);
    tick();
    ok = (codes.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (codes[i] != exp_seq[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_clean_seq got %0d events want 6 in order", codes.size()); end
    checks++;
    if (num_fill_bursts !== 23'd4) begin errors++; $display("FAIL mid_clean_nfb got %0d want 4", num_fill_bursts); end
  endtask

  initial begin
`ifdef SELFTRIG_DROP_CNT_EN
    exp_drop = 2;
`else
    exp_drop = 0;
`endif
    test_reset();
    test_basic_fill();
    test_addresses();
    test_drops();
    test_fifo_stall();
    test_cap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/selftrig_fill_sequencer.md
Name: selftrig_fill_sequencer

Overview:
Control sequencer for the self-triggered acquisition mux. It drives the mux's select, checksum_init and checksum_update strobes, and maintains the waveform number, waveform start address and fill burst count that go into the headers. Order per fill: checksum init, then one waveform block per accepted trigger (waveform header, then N data bursts), then a fill header, then a checksum. It sits between the trigger/ADC burst logic and the mux/DDR3 write FIFO.

Parameters:
MAX_WFM, 23'd8388607, waveform cap per fill; triggers beyond the cap are dropped.
DROP_W, 8, width of the dropped-trigger counter.

Ports:
clk  in  1  acquisition clock; mux and FIFO clock
rst_n  in  1  asynchronous active-low reset
fill_start  in  1  pulse; begin new fill
fill_end  in  1  pulse; close fill after the current waveform
trig  in  1  pulse; self-trigger request
adc_burst_valid  in  1  one 8-sample burst ready this cycle
fifo_ready  in  1  DDR3 write FIFO can accept (not almost-full)
async_num_bursts  in  14  data bursts per waveform; 0 is treated as 1
base_adr  in  23  DDR3 start address of the fill
select_fill_hdr  out  1  mux select
select_waveform_hdr  out  1  mux select
select_dat  out  1  mux select
select_checksum  out  1  mux select
checksum_init  out  1  clear mux checksum
checksum_update  out  1  XOR data into checksum
fifo_wr_en  out  1  write strobe, aligned to the registered mux output
current_waveform_num  out  23  waveform index / final count
waveform_start_adr  out  23  address of the current waveform header
num_fill_bursts  out  23  bursts written this fill, including trailer
fill_busy  out  1  high from INIT through CHKSUM
fill_done  out  1  one-cycle pulse after the checksum is issued
dropped_trig  out  DROP_W  triggers ignored this fill

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0; state IDLE; all counters 0.
- Only the state machine drives the strobes, and all strobes are registered. At most one select_* is high in any cycle.
- States and transitions:
  - IDLE: on fill_start, go to INIT.
  - INIT: checksum_init=1 for one cycle. Clear current_waveform_num and num_fill_bursts. Set waveform_start_adr=base_adr. Go to ARMED.
  - ARMED:
    - If fill_end, go to FILL_HDR. fill_end wins over a simultaneous trig; that trig is counted as dropped.
    - Else if trig and current_waveform_num<MAX_WFM, go to WFM_HDR.
    - Else if trig and the cap is reached, the trig is counted as dropped.
  - WFM_HDR:
    - Waits until fifo_ready=1.
    - Then asserts select_waveform_hdr for one cycle and sets waveform_start_adr=base_adr+num_fill_bursts. The waveform header therefore carries its own address.
    - Then loads burst_left=max(async_num_bursts,1) and goes to DATA.
  - DATA:
    - On each cycle with adc_burst_valid && fifo_ready: assert select_dat and checksum_update, decrement burst_left.
    - When burst_left reaches 0: increment current_waveform_num and go to ARMED.
    - adc_burst_valid with fifo_ready=0: the burst is lost. Set an internal overflow flag; burst_left is not decremented.
  - FILL_HDR: wait for fifo_ready, assert select_fill_hdr for one cycle, go to CHKSUM.
  - CHKSUM:
    - Entered no earlier than the cycle after FILL_HDR, so the mux checksum already includes the fill header.
    - Waits for fifo_ready, then asserts select_checksum for one cycle.
    - Then pulses fill_done and goes to IDLE.
- num_fill_bursts increments by 1 on every asserted select_* and wraps at 2^23. The value shown while select_fill_hdr is high already includes the fill header and the checksum (+2). It freezes after CHKSUM and is cleared in INIT.
- fifo_wr_en = any select_* delayed one cycle, matching the mux's registered output.
- trig in any state other than ARMED is dropped; fill_end outside ARMED/DATA is ignored.
- fill_end in DATA is latched; the sequencer finishes the waveform, then goes to FILL_HDR.
- fill_start while fill_busy is ignored.
- Reset mid-fill: immediate return to IDLE with all strobes 0. No trailer is emitted.

Optional Feature:
SELFTRIG_DROP_CNT_EN
- Defined: dropped_trig counts dropped triggers, saturating at 2^DROP_W-1, cleared in INIT. Bursts lost with fifo_ready=0 also count.
- Undefined: dropped_trig is tied to 0 and the counter logic is omitted.

Test Plan:
- async_num_bursts=4, fill_start, one trig, 4 valid bursts, fill_end → strobes in order: init, wfm_hdr, 4×dat, fill_hdr, checksum. num_fill_bursts=7, current_waveform_num=1, fill_done one cycle after the checksum.
- base_adr=100, 3 trigs with async_num_bursts=2 → waveform_start_adr=100, 103, 106; final num_fill_bursts=11.
- trig during DATA and trig together with fill_end → both dropped; dropped_trig=2 (macro on) or 0 (macro off).
- fifo_ready held low 5 cycles in WFM_HDR → header strobe delayed 5 cycles, no extra strobes; fifo_wr_en trails each select by exactly 1 cycle.
- MAX_WFM=2, 3 trigs → current_waveform_num=2, third trig dropped, fill trailer still emitted.
- rst_n low during DATA → all outputs 0 asynchronously; a following fill_start runs a clean fill from INIT.
